// File: rtl/button_pkg.sv
// Shared types and defaults for the pushbutton front-end (debounce FSM state,
// default timing constants, counter sizing helper).
package button_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMING,
    PRESSED,
    RELEASING
  } btn_state_e;

  localparam int unsigned DEF_DB_CYCLES     = 16;
  localparam int unsigned DEF_REPEAT_DELAY  = 64;
  localparam int unsigned DEF_REPEAT_PERIOD = 16;

  // Bits needed to count 0 .. n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM with saturating counter,
// press detect and (with BUTTON_REPEAT_EN defined) optional auto-repeat.
module debounce_channel
  import button_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter bit          REPEAT_EN     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic fire_o,   // pulse request for the coming edge, registered by the top
  output logic level_o
);

  localparam int unsigned           CW      = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0]         CNT_MAX = CW'(DB_CYCLES - 1);

  if (DB_CYCLES < 2 || (REPEAT_EN && (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0))) begin : g_bad_cfg
    $error("debounce_channel: invalid timing parameters");
  end

  logic       meta_q, sync_q;
  btn_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic       level_q;
  logic       press;
  logic       rpt_fire;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (sync_q) begin
          state_q <= ARMING;
          cnt_q   <= '0;
        end
        ARMING: if (!sync_q) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else if (cnt_q == CNT_MAX) begin
          state_q <= PRESSED;
          level_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        PRESSED: if (!sync_q) begin
          state_q <= RELEASING;
          cnt_q   <= '0;
        end
        RELEASING: if (sync_q) begin
          state_q <= PRESSED;
          cnt_q   <= '0;
        end else if (cnt_q == CNT_MAX) begin
          state_q <= IDLE;
          level_q <= 1'b0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign press = (state_q == ARMING) && sync_q && (cnt_q == CNT_MAX);

`ifdef BUTTON_REPEAT_EN
  if (REPEAT_EN) begin : g_rpt
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = cnt_width(RMAX);

    logic [RW-1:0] rcnt_q;
    logic [RW-1:0] rlim;
    logic          rfirst_q;
    logic          held;
    logic          going_idle;

    // Repeat timing is anchored to the accepted press; release bounce does not restart it.
    assign held       = (state_q == PRESSED) || (state_q == RELEASING);
    assign going_idle = (state_q == RELEASING) && !sync_q && (cnt_q == CNT_MAX);
    assign rlim       = rfirst_q ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
    assign rpt_fire   = held && !going_idle && (rcnt_q == rlim);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rcnt_q   <= '0;
        rfirst_q <= 1'b1;
      end else if (press) begin
        rcnt_q   <= '0;
        rfirst_q <= 1'b1;
      end else if (held) begin
        if (rpt_fire) begin
          rcnt_q   <= '0;
          rfirst_q <= 1'b0;
        end else begin
          rcnt_q <= rcnt_q + 1'b1;
        end
      end
    end
  end else begin : g_no_rpt
    assign rpt_fire = 1'b0;
  end
`else
  assign rpt_fire = 1'b0;
`endif

  assign fire_o  = press | rpt_fire;
  assign level_o = level_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the up/down/next pushbuttons into one-cycle press pulses for the
// bicycle light FSM. Define BUTTON_REPEAT_EN to add auto-repeat on up/down.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset_n,
  input  logic up_raw,
  input  logic down_raw,
  input  logic next_raw,
  output logic up_pulse,
  output logic down_pulse,
  output logic next_pulse,
  output logic up_level,
  output logic down_level,
  output logic next_level
);

  logic up_fire, down_fire, next_fire;
  logic up_pulse_q, down_pulse_q, next_pulse_q;

  debounce_channel #(
    .DB_CYCLES    (DB_CYCLES),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .REPEAT_EN    (1'b1)
  ) u_up (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .raw_i  (up_raw),
    .fire_o (up_fire),
    .level_o(up_level)
  );

  debounce_channel #(
    .DB_CYCLES    (DB_CYCLES),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .REPEAT_EN    (1'b1)
  ) u_down (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .raw_i  (down_raw),
    .fire_o (down_fire),
    .level_o(down_level)
  );

  debounce_channel #(
    .DB_CYCLES    (DB_CYCLES),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .REPEAT_EN    (1'b0)
  ) u_next (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .raw_i  (next_raw),
    .fire_o (next_fire),
    .level_o(next_level)
  );

  // Simultaneous up and down requests cancel each other.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      up_pulse_q   <= 1'b0;
      down_pulse_q <= 1'b0;
      next_pulse_q <= 1'b0;
    end else begin
      up_pulse_q   <= up_fire & ~down_fire;
      down_pulse_q <= down_fire & ~up_fire;
      next_pulse_q <= next_fire;
    end
  end

  assign up_pulse   = up_pulse_q;
  assign down_pulse = down_pulse_q;
  assign next_pulse = next_pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with DB_CYCLES=4 (REPEAT 8/4 when
// BUTTON_REPEAT_EN is defined): history-based model plus directed timing checks.
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RP = 4;
`ifdef BUTTON_REPEAT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif
  // Pulses during a 20-cycle hold released cleanly: 6 (+14,18,22 with repeat)
  localparam int HOLD_PULSES = RPT ? 4 : 1;

  logic clk      = 1'b0;
  logic reset_n  = 1'b0;
  logic up_raw   = 1'b0;
  logic down_raw = 1'b0;
  logic next_raw = 1'b0;
  logic up_pulse, down_pulse, next_pulse;
  logic up_level, down_level, next_level;

  button_conditioner #(
    .DB_CYCLES    (DB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .up_raw    (up_raw),
    .down_raw  (down_raw),
    .next_raw  (next_raw),
    .up_pulse  (up_pulse),
    .down_pulse(down_pulse),
    .next_pulse(next_pulse),
    .up_level  (up_level),
    .down_level(down_level),
    .next_level(next_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  logic [2:0] raw_v, dut_p, dut_l;
  assign raw_v = {next_raw, down_raw, up_raw};
  assign dut_p = {next_pulse, down_pulse, up_pulse};
  assign dut_l = {next_level, down_level, up_level};

  // Model: level flips once the last DB+1 synchronised samples (raw delayed by
  // two edges) all disagree with it; a rise is a press, repeats count from it.
  bit hist [3][DB+3];
  bit m_lvl [3];
  int m_age [3];
  bit m_cand [3];
  bit exp_pulse [3];
  bit exp_level [3];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 3; c++) begin
        for (int k = 0; k < DB + 3; k++) hist[c][k] = 1'b0;
        m_lvl[c] = 1'b0; m_age[c] = 0; m_cand[c] = 1'b0;
        exp_pulse[c] = 1'b0; exp_level[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        bit flip;
        for (int k = DB + 2; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = raw_v[c];
        flip = 1'b1;
        for (int k = 2; k <= DB + 2; k++) if (hist[c][k] == m_lvl[c]) flip = 1'b0;
        m_cand[c] = 1'b0;
        if (flip) begin
          m_lvl[c] = !m_lvl[c];
          if (m_lvl[c]) begin
            m_cand[c] = 1'b1;
            m_age[c]  = 0;
          end
        end else if (m_lvl[c]) begin
          m_age[c]++;
          if (RPT && c != 2 && m_age[c] >= RD && (m_age[c] - RD) % RP == 0) m_cand[c] = 1'b1;
        end
      end
      exp_pulse[0] = m_cand[0] && !m_cand[1];
      exp_pulse[1] = m_cand[1] && !m_cand[0];
      exp_pulse[2] = m_cand[2];
      for (int c = 0; c < 3; c++) exp_level[c] = m_lvl[c];
    end
  end

  string nm [3] = '{"up", "down", "next"};

  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      check({nm[c], "_pulse"}, int'(dut_p[c]), int'(exp_pulse[c]));
      check({nm[c], "_level"}, int'(dut_l[c]), int'(exp_level[c]));
    end
  end

  // Observation of the DUT for directed timing expectations.
  int obs_idx;
  int pcnt [3];
  int pfirst [3];
  int lrise [3];
  int lfall [3];
  bit prev_l [3];

  task automatic obs_start();
    obs_idx = 0;
    for (int c = 0; c < 3; c++) begin
      pcnt[c] = 0; pfirst[c] = -1; lrise[c] = -1; lfall[c] = -1;
      prev_l[c] = dut_l[c];
    end
  endtask

  task automatic observe(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        if (dut_p[c]) begin
          if (pfirst[c] < 0) pfirst[c] = obs_idx;
          pcnt[c]++;
        end
        if (dut_l[c] && !prev_l[c] && lrise[c] < 0) lrise[c] = obs_idx;
        if (!dut_l[c] && prev_l[c] && lfall[c] < 0) lfall[c] = obs_idx;
        prev_l[c] = dut_l[c];
      end
      obs_idx++;
    end
    #1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", int'({dut_p, dut_l}), 0);
    reset_n = 1'b1;
    observe(4);

    // Clean up press, held 20 cycles then released.
    obs_start();
    up_raw = 1'b1; observe(20);
    up_raw = 1'b0; observe(12);
    check("clean_up_first", pfirst[0], DB + 2);
    check("clean_up_rise",  lrise[0], DB + 2);
    check("clean_up_count", pcnt[0], HOLD_PULSES);
    check("clean_up_fall",  lfall[0], 20 + DB + 2);
    check("clean_others",   pcnt[1] + pcnt[2], 0);

    // Press bounce on next: 1,0,1,0 then held.
    obs_start();
    next_raw = 1'b1; observe(1);
    next_raw = 1'b0; observe(1);
    next_raw = 1'b1; observe(1);
    next_raw = 1'b0; observe(1);
    next_raw = 1'b1; observe(20);
    next_raw = 1'b0; observe(12);
    check("bounce_next_first", pfirst[2], 4 + DB + 2);
    check("bounce_next_count", pcnt[2], 1);
    check("bounce_next_rise",  lrise[2], 4 + DB + 2);
    check("bounce_next_fall",  lfall[2], 24 + DB + 2);

    // Release bounce on down: 2-cycle drop during the hold.
    obs_start();
    down_raw = 1'b1; observe(12);
    down_raw = 1'b0; observe(2);
    down_raw = 1'b1; observe(6);
    down_raw = 1'b0; observe(12);
    check("relb_down_first", pfirst[1], DB + 2);
    check("relb_down_count", pcnt[1], HOLD_PULSES);
    check("relb_down_fall",  lfall[1], 20 + DB + 2);

    // Simultaneous up/down, next one cycle later.
    obs_start();
    up_raw = 1'b1; down_raw = 1'b1; observe(1);
    next_raw = 1'b1; observe(15);
    up_raw = 1'b0; down_raw = 1'b0; next_raw = 1'b0; observe(12);
    check("simul_up_count",   pcnt[0], 0);
    check("simul_down_count", pcnt[1], 0);
    check("simul_up_rise",    lrise[0], DB + 2);
    check("simul_down_rise",  lrise[1], DB + 2);
    check("simul_next_first", pfirst[2], 1 + DB + 2);
    check("simul_next_count", pcnt[2], 1);

    // Reset during ARMING with up still held.
    obs_start();
    up_raw = 1'b1; observe(3);
    reset_n = 1'b0; #1;
    check("rst_async_clear", int'({dut_p, dut_l}), 0);
    observe(2);
    check("rst_held_clear", int'({dut_p, dut_l}), 0);
    obs_start();
    reset_n = 1'b1; observe(12);
    check("rst_up_first", pfirst[0], DB + 2);
    check("rst_up_count", pcnt[0], 1);
    check("rst_up_rise",  lrise[0], DB + 2);
    up_raw = 1'b0; observe(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end stage directly upstream of the bicycle light FSM.
- Takes the three raw pushbutton inputs (up, down, next) and conditions each one: synchronise, debounce, then convert to a single-cycle press pulse.
- The pulse outputs connect straight to the FSM's up_button, down_button and next inputs.
- Three identical channels, plus a cross-channel up/down conflict rule.

Parameters:
- DB_CYCLES, 16, consecutive stable synchronised samples required to accept a level change (min 2).
- REPEAT_DELAY, 64, cycles held in PRESSED before the first auto-repeat pulse (used only with the optional feature).
- REPEAT_PERIOD, 16, cycles between subsequent auto-repeat pulses (used only with the optional feature).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- up_raw  input  1  raw up button, asynchronous, active-high
- down_raw  input  1  raw down button, asynchronous, active-high
- next_raw  input  1  raw next button, asynchronous, active-high
- up_pulse  output  1  one-cycle press pulse, feeds FSM up_button
- down_pulse  output  1  one-cycle press pulse, feeds FSM down_button
- next_pulse  output  1  one-cycle press pulse, feeds FSM next
- up_level  output  1  debounced held level
- down_level  output  1  debounced held level
- next_level  output  1  debounced held level

Behaviour:
- Reset: asserting reset_n low immediately clears all state. Every channel goes to IDLE, counters and synchroniser flops go to 0, and all outputs go to 0.
- Synchroniser: 2 flops per channel, reset value 0. The debounce FSM uses the second flop output (sync).
- Per-channel FSM:
  - IDLE: sync=1 -> ARMING, cnt=0.
  - ARMING: sync=0 -> IDLE, cnt=0. Otherwise if cnt==DB_CYCLES-1 -> PRESSED, else cnt+1.
  - PRESSED: sync=0 -> RELEASING, cnt=0.
  - RELEASING: sync=1 -> PRESSED, cnt=0. Otherwise if cnt==DB_CYCLES-1 -> IDLE, else cnt+1.
- Counter width: clog2(DB_CYCLES). The counter saturates and never wraps.
- level outputs: 1 in PRESSED and RELEASING, 0 in IDLE and ARMING. All outputs are registered.
- pulse outputs: high for exactly one cycle, the cycle in which the state first becomes PRESSED from ARMING. A RELEASING->PRESSED transition (release bounce) produces no pulse.
- Latency: for a clean rise sampled at edge e0, the pulse is visible after edge e0+DB_CYCLES+2. Example: DB_CYCLES=4 gives the pulse after the 6th edge. level rises on the same edge as the pulse.
- Bounce: any glitch shorter than DB_CYCLES cycles produces no pulse and no level change.
- Conflict rule: if up and down would pulse in the same cycle, both are suppressed and neither fires later for that press. Their levels still go high. next is unaffected.
- Reset mid-count: in-progress debounce is discarded. A button held through reset release is treated as a new press and produces one pulse after the full latency.

Optional Feature:
- Macro: BUTTON_REPEAT_EN.
- Defined: up and down channels have a repeat counter.
  - Counter clears on entering PRESSED.
  - While in PRESSED or RELEASING, the channel emits an extra one-cycle pulse REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles until the state returns to IDLE.
  - Repeat pulses obey the conflict rule.
  - next never repeats.
- Undefined: exactly one pulse per accepted press. The repeat logic and REPEAT_* parameters are unused and no repeat hardware is synthesised.

Decomposition:
- Shared package button_pkg:
  - state enum (IDLE, ARMING, PRESSED, RELEASING).
  - default DB_CYCLES/REPEAT_* constants.
  - counter-width function.
- One sub-module, debounce_channel. It contains the synchroniser, FSM, counter and optional repeat logic, and has a per-instance repeat enable tied low for next.
- The top instantiates it three times and applies the conflict rule.

Test Plan:
- Clean press, DB_CYCLES=4: up_raw 0->1 held for 20 cycles -> up_pulse high for exactly 1 cycle after edge 6, up_level=1 from the same edge. No other pulse.
- Press bounce: next_raw toggles 1,0,1,0 on alternate cycles, then held high -> no pulse during the toggling. Exactly one next_pulse DB_CYCLES+2 edges after the final rise.
- Release bounce: during a held press, down_raw drops for 2 cycles (below DB_CYCLES) then returns high -> down_level stays 1 and no second pulse. A clean release drops down_level DB_CYCLES+2 edges later.
- Simultaneous: up_raw and down_raw rise on the same edge -> no up_pulse or down_pulse at any time, both levels go to 1. A next press in the same window still pulses.
- Reset mid-count: reset_n low during ARMING with up_raw still high, then released -> outputs 0 while reset is low. One up_pulse DB_CYCLES+2 edges after reset_n deasserts.
- With BUTTON_REPEAT_EN, REPEAT_DELAY=8, REPEAT_PERIOD=4: up held 30 cycles -> pulses at t0, t0+8, t0+12, t0+16…, stopping after release completes. next held the same way -> single pulse.
